switch_cfg_loader: RTL and testbench

Streams configuration words from a host into an array of `switch_box` tiles. Accepts a framed word stream over a valid/ready handshake, decodes each tile address, and drives the shared 32-bit `config_data` bus with a one-cycle one-hot `config_en` strobe to the addressed tile. Sits between the host or boot interface and the fabric's switch-box column. Reports progress, completion and framing errors.

---
 rtl/switch_cfg_pkg.sv | 22 ++
 rtl/switch_cfg_loader.sv | 163 ++++++++++++++++
 tb/tb_switch_cfg_loader.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/switch_cfg_pkg.sv
// Shared constants, state encoding and header helper for the switch-box
// configuration loader.
package switch_cfg_pkg;

  localparam logic [7:0] CFG_MAGIC  = 8'hC5;
  localparam int         CFG_WORD_W = 32;
  localparam int         CFG_CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } cfg_state_t;

  // A word opens a frame only when its top byte carries the magic tag.
  function automatic logic is_cfg_magic(input logic [7:0] tag);
    return (tag == CFG_MAGIC);
  endfunction

endpackage

// File: rtl/switch_cfg_loader.sv
// Frame-driven configuration loader: takes header/address/data words from a
// host and writes each data word to one switch-box tile via a one-hot strobe.
module switch_cfg_loader
  import switch_cfg_pkg::*;
#(
  parameter int NUM_TILES = 16,
  parameter int ADDR_W    = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CFG_WORD_W-1:0] in_data,
  output logic [CFG_WORD_W-1:0] config_data,
  output logic [NUM_TILES-1:0]  config_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output cfg_state_t            dbg_state
);

  // Handshake: a word moves only in a cycle where in_valid && in_ready.
  // in_ready is a pure decode of state (high in IDLE, ADDR, DATA) and never
  // depends on in_valid; the host may hold a word indefinitely.

  cfg_state_t            r_state;
  cfg_state_t            w_next_state;
  logic [CFG_CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_skip;
  logic [CFG_WORD_W-1:0] r_cfg_data;
  logic [NUM_TILES-1:0]  r_cfg_en;
  logic                  r_done;
  logic                  r_error;

  logic                  w_ready;
  logic                  w_busy;
  logic                  w_xfer;
  logic                  w_hdr_ok;
  logic                  w_addr_oob;
  logic [NUM_TILES-1:0]  w_onehot;

  assign w_xfer     = in_valid && w_ready;
  assign w_hdr_ok   = is_cfg_magic(in_data[CFG_WORD_W-1 -: 8]);
  // Full-width compare so nonzero upper bits also mark the address as out of range.
  assign w_addr_oob = (in_data >= CFG_WORD_W'(NUM_TILES));

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_TILES; i++) begin
      w_onehot[i] = (r_addr == ADDR_W'(i));
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_xfer && w_hdr_ok) begin
          w_next_state = (in_data[CFG_CNT_W-1:0] == '0) ? DONE : ADDR;
        end
      end
      ADDR: begin
        if (w_xfer) w_next_state = DATA;
      end
      DATA: begin
        if (w_xfer) w_next_state = WRITE;
      end
      WRITE: begin
        w_next_state = (r_cnt != '0) ? ADDR : DONE;
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    w_ready = 1'b0;
    w_busy  = 1'b1;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        w_busy  = 1'b0;
      end
      ADDR:    w_ready = 1'b1;
      DATA:    w_ready = 1'b1;
      WRITE:   w_ready = 1'b0;
      DONE:    w_ready = 1'b0;
      default: w_ready = 1'b0;
    endcase
  end

  // Strobe, done and error are registered so they line up with WRITE/DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_skip     <= 1'b0;
      r_cfg_data <= '0;
      r_cfg_en   <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_cfg_en <= '0;
      r_done   <= (w_next_state == DONE);
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            if (w_hdr_ok) begin
              r_cnt   <= in_data[CFG_CNT_W-1:0];
              r_error <= 1'b0;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (w_xfer) begin
            r_addr <= in_data[ADDR_W-1:0];
            r_skip <= w_addr_oob;
          end
        end
        DATA: begin
          if (w_xfer) begin
            r_cfg_data <= in_data;
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            if (r_skip) begin
              r_error <= 1'b1;
            end else begin
              r_cfg_en <= w_onehot;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready    = w_ready;
  assign busy        = w_busy;
  assign config_data = r_cfg_data;
  assign config_en   = r_cfg_en;
  assign done        = r_done;
  assign error       = r_error;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_switch_cfg_loader.sv
// Directed bench for switch_cfg_loader: framed writes, empty frame, bad magic,
// out-of-range addresses, host stalls and reset in the middle of a write.
module tb_switch_cfg_loader;
  import switch_cfg_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] config_data;
  logic [15:0] config_en;
  logic        busy;
  logic        done;
  logic        error;
  cfg_state_t  dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int strobe_cnt = 0;
  int multi_cnt  = 0;
  int done_cnt   = 0;
  int hdr_cyc;
  int tmp_cyc;

  switch_cfg_loader #(.NUM_TILES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .config_data(config_data),
    .config_en  (config_en),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Whole-run strobe and done bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (config_en != 16'h0) strobe_cnt <= strobe_cnt + 1;
      if ($countones(config_en) > 1) multi_cnt <= multi_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: present a word from a negedge, wait (bounded) for ready, return
  // at the negedge after the transfer edge with in_valid dropped.
  task automatic send(input logic [31:0] w, output int acc_cyc);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("send_ready", {31'b0, in_ready}, 32'h1);
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'h0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_busy",  {31'b0, busy},     32'h0);
    chk("rst_en",    {16'b0, config_en}, 32'h0);
    chk("rst_data",  config_data,       32'h0);
    chk("rst_done",  {31'b0, done},     32'h0);
    chk("rst_error", {31'b0, error},    32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Two-pair frame, host valid held high
    send(32'hC500_0002, hdr_cyc);
    chk("t1_busy", {31'b0, busy}, 32'h1);
    send(32'h0000_0003, tmp_cyc);
    send(32'h00AA_55FF, tmp_cyc);
    chk("t1_en0",   {16'b0, config_en}, 32'h0000_0008);
    chk("t1_data0", config_data,        32'h00AA_55FF);
    chk("t1_ready_write", {31'b0, in_ready}, 32'h0);
    send(32'h0000_0000, tmp_cyc);
    send(32'h1234_5678, tmp_cyc);
    chk("t1_en1",   {16'b0, config_en}, 32'h0000_0001);
    chk("t1_data1", config_data,        32'h1234_5678);
    @(negedge clk);
    chk("t1_done",     {31'b0, done},  32'h1);
    chk("t1_done_lat", cyc - hdr_cyc,  32'd7);
    chk("t1_error",    {31'b0, error}, 32'h0);
    chk("t1_en_off",   {16'b0, config_en}, 32'h0);
    chk("t1_data_hold", config_data,   32'h1234_5678);

    // Empty frame
    send(32'hC500_0000, hdr_cyc);
    chk("t2_done",     {31'b0, done}, 32'h1);
    chk("t2_done_lat", cyc - hdr_cyc, 32'd1);
    @(negedge clk);
    chk("t2_done_off", {31'b0, done}, 32'h0);
    chk("t2_busy",     {31'b0, busy}, 32'h0);

    // Bad magic, then a good header clears error
    send(32'h7F00_0001, tmp_cyc);
    chk("t3_error",  {31'b0, error},    32'h1);
    chk("t3_busy",   {31'b0, busy},     32'h0);
    chk("t3_ready",  {31'b0, in_ready}, 32'h1);
    send(32'hC500_0001, tmp_cyc);
    chk("t3_busy_hdr",   {31'b0, busy},  32'h1);
    chk("t3_error_clr",  {31'b0, error}, 32'h0);
    send(32'h0000_0005, tmp_cyc);
    send(32'hCAFE_F00D, tmp_cyc);
    chk("t3_en", {16'b0, config_en}, 32'h0000_0020);
    @(negedge clk);
    chk("t3_done", {31'b0, done}, 32'h1);

    // Address 20 is out of range: no strobe, error with done
    send(32'hC500_0001, tmp_cyc);
    send(32'd20, tmp_cyc);
    send(32'hFFFF_FFFF, tmp_cyc);
    chk("t4_en",    {16'b0, config_en}, 32'h0);
    chk("t4_data",  config_data,        32'hFFFF_FFFF);
    @(negedge clk);
    chk("t4_done",  {31'b0, done},  32'h1);
    chk("t4_error", {31'b0, error}, 32'h1);

    // Upper address bits set with in-range low bits: still skipped
    send(32'hC500_0001, tmp_cyc);
    chk("t4b_error_clr", {31'b0, error}, 32'h0);
    send(32'h8000_0002, tmp_cyc);
    send(32'h0000_0033, tmp_cyc);
    chk("t4b_en",    {16'b0, config_en}, 32'h0);
    chk("t4b_error", {31'b0, error},     32'h1);
    @(negedge clk);
    chk("t4b_done",  {31'b0, done}, 32'h1);

    // Host stalls five cycles between address and data
    send(32'hC500_0001, tmp_cyc);
    send(32'h0000_0007, tmp_cyc);
    for (int i = 0; i < 5; i++) begin
      chk("t5_busy_stall", {31'b0, busy},     32'h1);
      chk("t5_en_stall",   {16'b0, config_en}, 32'h0);
      @(negedge clk);
    end
    chk("t5_ready_stall", {31'b0, in_ready}, 32'h1);
    send(32'h0BAD_F00D, tmp_cyc);
    chk("t5_en",   {16'b0, config_en}, 32'h0000_0080);
    chk("t5_data", config_data,        32'h0BAD_F00D);
    @(negedge clk);
    chk("t5_done", {31'b0, done}, 32'h1);

    // Reset during WRITE
    send(32'hC500_0001, tmp_cyc);
    send(32'h0000_0009, tmp_cyc);
    send(32'hDEAD_BEEF, tmp_cyc);
    chk("t6_en_pre", {16'b0, config_en}, 32'h0000_0200);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_en_async",   {16'b0, config_en}, 32'h0);
    chk("t6_busy_async", {31'b0, busy},      32'h0);
    chk("t6_data_async", config_data,        32'h0);
    @(negedge clk);
    reset = 1'b1;
    chk("t6_error_rel", {31'b0, error},    32'h0);
    chk("t6_ready_rel", {31'b0, in_ready}, 32'h1);
    send(32'hC500_0001, tmp_cyc);
    chk("t6_busy_hdr", {31'b0, busy}, 32'h1);
    send(32'h0000_0001, tmp_cyc);
    send(32'h0000_0005, tmp_cyc);
    chk("t6_en", {16'b0, config_en}, 32'h0000_0002);
    @(negedge clk);
    chk("t6_done", {31'b0, done}, 32'h1);
    @(negedge clk);

    // Run-wide totals
    chk("strobe_total", strobe_cnt, 32'd6);
    chk("multi_hot",    multi_cnt,  32'd0);
    chk("done_total",   done_cnt,   32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
